// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding word fetch from pc into a DEPTH-entry {pc, instr} FIFO toward decode.
// Define INSTR_FETCH_STATS_EN to add saturating fetch_count / discard_count outputs.
module instr_fetch #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            Reset,
   input  logic [XLEN-1:0] pc,
   output logic            pc_inc,
   input  logic            flush,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            instr_valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            instr_ready
`ifdef INSTR_FETCH_STATS_EN
   ,
   output logic [31:0]     fetch_count,
   output logic [15:0]     discard_count
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_REQ     = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] mem_addr_q, mem_addr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] fifo_instr_q [DEPTH];
   logic [XLEN-1:0] fifo_instr_d [DEPTH];
   logic [XLEN-1:0] fifo_pc_q [DEPTH];
   logic [XLEN-1:0] fifo_pc_d [DEPTH];
   logic            push, drop, pop;

   always_comb begin
      state_d    = state_q;
      mem_addr_d = mem_addr_q;
      push       = 1'b0;
      drop       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!flush && (count_q < DEPTH_C)) begin
               mem_addr_d = pc;
               state_d    = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               state_d = S_IDLE;
               push    = !flush;
               drop    = flush;
            end else if (flush) begin
               state_d = S_DISCARD;
            end
         end
         S_DISCARD: begin
            // The request stays up until acked; its data is stale after the flush.
            if (mem_ack) begin
               state_d = S_IDLE;
               drop    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign pop = instr_valid && instr_ready && !flush;

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      fifo_instr_d = fifo_instr_q;
      fifo_pc_d    = fifo_pc_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            fifo_instr_d[wr_ptr_q] = mem_rdata;
            fifo_pc_d[wr_ptr_q]    = mem_addr_q;
            wr_ptr_d               = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         mem_addr_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         fifo_instr_q <= '{default: '0};
         fifo_pc_q    <= '{default: '0};
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fifo_instr_q <= fifo_instr_d;
         fifo_pc_q    <= fifo_pc_d;
      end
   end

   assign pc_inc      = push;
   assign mem_req     = (state_q == S_REQ) || (state_q == S_DISCARD);
   assign mem_addr    = mem_addr_q;
   assign instr_valid = (count_q != '0);
   assign instr       = fifo_instr_q[rd_ptr_q];
   assign instr_pc    = fifo_pc_q[rd_ptr_q];

`ifdef INSTR_FETCH_STATS_EN
   logic [31:0] fetch_count_q, fetch_count_d;
   logic [15:0] discard_count_q, discard_count_d;

   always_comb begin
      fetch_count_d   = fetch_count_q;
      discard_count_d = discard_count_q;
      if (push && (fetch_count_q != '1)) fetch_count_d = fetch_count_q + 32'd1;
      if (drop && (discard_count_q != '1)) discard_count_d = discard_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         fetch_count_q   <= '0;
         discard_count_q <= '0;
      end else begin
         fetch_count_q   <= fetch_count_d;
         discard_count_q <= discard_count_d;
      end
   end

   assign fetch_count   = fetch_count_q;
   assign discard_count = discard_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a PC register model plus a memory with programmable ack delay.
module tb_instr_fetch;

   logic        clk;
   logic        Reset;
   logic [31:0] pc;
   logic        pc_inc;
   logic        flush;
   logic [31:0] flush_tgt;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
`ifdef INSTR_FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [15:0] discard_count;
`endif

   int total = 0;
   int bad   = 0;
   int unsigned ack_delay = 0;
   int unsigned wait_cnt;

   instr_fetch #(.DEPTH(2), .XLEN(32)) dut (
      .clk         (clk),
      .Reset       (Reset),
      .pc          (pc),
      .pc_inc      (pc_inc),
      .flush       (flush),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
`ifdef INSTR_FETCH_STATS_EN
      ,
      .fetch_count   (fetch_count),
      .discard_count (discard_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // PC register: increment has priority over load.
   always @(posedge clk or posedge Reset) begin
      if (Reset)       pc <= '0;
      else if (pc_inc) pc <= pc + 32'd1;
      else if (flush)  pc <= flush_tgt;
   end

   // Memory acks after ack_delay wait cycles; data encodes the address.
   assign mem_ack   = mem_req && (wait_cnt == ack_delay);
   assign mem_rdata = 32'hA000_0000 | mem_addr;
   always @(posedge clk or posedge Reset) begin
      if (Reset)                    wait_cnt <= 0;
      else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
      else                          wait_cnt <= 0;
   end

   task automatic do_reset();
      Reset = 1'b1;
      flush = 1'b0;
      instr_ready = 1'b0;
      ack_delay = 0;
      @(negedge clk);
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      flush = 1'b0;
      flush_tgt = '0;
      instr_ready = 1'b0;
      #1 Reset = 1'b1;
      #2;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
      total++; if (pc_inc !== 1'b0) begin bad++; $display("FAIL reset_pc_inc got=%b exp=0", pc_inc); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
      total++; if (instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", instr); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc); end
`ifdef INSTR_FETCH_STATS_EN
      total++; if (fetch_count !== 32'h0) begin bad++; $display("FAIL reset_fetch_count got=%0d exp=0", fetch_count); end
      total++; if (discard_count !== 16'h0) begin bad++; $display("FAIL reset_discard_count got=%0d exp=0", discard_count); end
`endif
   endtask

   // Zero-wait stream: odd cycles are REQ with ack, even cycles show the pushed entry.
   task automatic test_zero_wait();
      logic [31:0] idx;
      do_reset();
      instr_ready = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k % 2 == 1) begin
            idx = 32'((k - 1) / 2);
            total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL zw_mem_req k=%0d got=%b exp=1", k, mem_req); end
            total++; if (mem_addr !== idx) begin bad++; $display("FAIL zw_mem_addr k=%0d got=%h exp=%h", k, mem_addr, idx); end
            total++; if (pc_inc !== 1'b1) begin bad++; $display("FAIL zw_pc_inc k=%0d got=%b exp=1", k, pc_inc); end
            total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL zw_valid_low k=%0d got=%b exp=0", k, instr_valid); end
         end else begin
            idx = 32'(k / 2 - 1);
            total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL zw_idle_req k=%0d got=%b exp=0", k, mem_req); end
            total++; if (pc_inc !== 1'b0) begin bad++; $display("FAIL zw_idle_inc k=%0d got=%b exp=0", k, pc_inc); end
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid k=%0d got=%b exp=1", k, instr_valid); end
            total++; if (instr_pc !== idx) begin bad++; $display("FAIL zw_instr_pc k=%0d got=%h exp=%h", k, instr_pc, idx); end
            total++; if (instr !== (32'hA000_0000 | idx)) begin bad++; $display("FAIL zw_instr k=%0d got=%h exp=%h", k, instr, 32'hA000_0000 | idx); end
         end
      end
   endtask

   task automatic test_backpressure();
      int acks = 0;
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (mem_req && mem_ack) acks++;
      end
      total++; if (acks != 2) begin bad++; $display("FAIL bp_ack_count got=%0d exp=2", acks); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_req_stalled got=%b exp=0", mem_req); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL bp_head_pc got=%h exp=0", instr_pc); end
      instr_ready = 1'b1;
      @(negedge clk);
      total++; if (instr_pc !== 32'h1) begin bad++; $display("FAIL bp_second_pc got=%h exp=1", instr_pc); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%b exp=0", mem_req); end
      @(negedge clk);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL bp_resume_req got=%b exp=1", mem_req); end
      total++; if (mem_addr !== 32'h2) begin bad++; $display("FAIL bp_resume_addr got=%h exp=2", mem_addr); end
   endtask

   task automatic test_discard();
      do_reset();
      instr_ready = 1'b1;
      ack_delay = 3;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      flush_tgt = 32'h40;
      #1;
      total++; if (pc_inc !== 1'b0) begin bad++; $display("FAIL dis_flush_inc got=%b exp=0", pc_inc); end
      @(negedge clk);
      flush = 1'b0;
      #1;
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL dis_req_held got=%b exp=1", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL dis_addr_held got=%h exp=0", mem_addr); end
      @(negedge clk);
      total++; if (mem_ack !== 1'b1) begin bad++; $display("FAIL dis_ack_arrives got=%b exp=1", mem_ack); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL dis_addr_at_ack got=%h exp=0", mem_addr); end
      total++; if (pc_inc !== 1'b0) begin bad++; $display("FAIL dis_ack_inc got=%b exp=0", pc_inc); end
      @(negedge clk);
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL dis_no_push got=%b exp=0", instr_valid); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL dis_idle_req got=%b exp=0", mem_req); end
      @(negedge clk);
      total++; if (mem_addr !== 32'h40) begin bad++; $display("FAIL dis_new_target got=%h exp=40", mem_addr); end
      repeat (3) @(negedge clk);
      total++; if (pc_inc !== 1'b1) begin bad++; $display("FAIL dis_target_inc got=%b exp=1", pc_inc); end
      @(negedge clk);
      total++; if (instr_pc !== 32'h40) begin bad++; $display("FAIL dis_target_pc got=%h exp=40", instr_pc); end
   endtask

   task automatic test_flush_with_ack();
      do_reset();
      repeat (3) @(negedge clk);
      total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL fa_one_entry got=%b exp=1", instr_valid); end
      total++; if (mem_ack !== 1'b1) begin bad++; $display("FAIL fa_ack got=%b exp=1", mem_ack); end
      flush = 1'b1;
      flush_tgt = 32'h80;
      #1;
      total++; if (pc_inc !== 1'b0) begin bad++; $display("FAIL fa_pc_inc got=%b exp=0", pc_inc); end
      @(negedge clk);
      flush = 1'b0;
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fa_cleared got=%b exp=0", instr_valid); end
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fa_idle got=%b exp=0", mem_req); end
      @(negedge clk);
      total++; if (mem_addr !== 32'h80) begin bad++; $display("FAIL fa_target got=%h exp=80", mem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL fa_no_push got=%b exp=0", instr_valid); end
   endtask

   // DEPTH=2 never issues with two entries held, so reset lands mid-REQ with one entry buffered.
   task automatic test_reset_mid_req();
      do_reset();
      repeat (2) @(negedge clk);
      ack_delay = 5;
      @(negedge clk);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rm_in_req got=%b exp=1", mem_req); end
      #2 Reset = 1'b1;
      #1;
      total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%b exp=0", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rm_addr got=%h exp=0", mem_addr); end
      total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", instr_valid); end
      total++; if (instr !== 32'h0) begin bad++; $display("FAIL rm_instr got=%h exp=0", instr); end
      total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rm_instr_pc got=%h exp=0", instr_pc); end
      @(negedge clk);
      Reset = 1'b0;
      ack_delay = 0;
      @(negedge clk);
      total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rm_restart_req got=%b exp=1", mem_req); end
      total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rm_restart_addr got=%h exp=0", mem_addr); end
   endtask

`ifdef INSTR_FETCH_STATS_EN
   task automatic test_stats();
      do_reset();
      instr_ready = 1'b1;
      @(negedge clk);
      flush = 1'b1;
      flush_tgt = 32'h10;
      @(negedge clk);
      flush = 1'b0;
      ack_delay = 3;
      repeat (2) @(negedge clk);
      flush = 1'b1;
      flush_tgt = 32'h20;
      @(negedge clk);
      flush = 1'b0;
      @(negedge clk);
      total++; if (mem_ack !== 1'b1) begin bad++; $display("FAIL st_discard_ack got=%b exp=1", mem_ack); end
      @(negedge clk);
      ack_delay = 0;
      @(negedge clk);
      total++; if (mem_addr !== 32'h20) begin bad++; $display("FAIL st_target got=%h exp=20", mem_addr); end
      repeat (7) @(negedge clk);
      total++; if (fetch_count !== 32'd4) begin bad++; $display("FAIL st_fetch_count got=%0d exp=4", fetch_count); end
      total++; if (discard_count !== 16'd2) begin bad++; $display("FAIL st_discard_count got=%0d exp=2", discard_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_zero_wait();
      test_backpressure();
      test_discard();
      test_flush_with_ack();
      test_reset_mid_req();
`ifdef INSTR_FETCH_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
